// File: rtl/encap_out_streamer_pkg.sv
// ============================================================================
// Module   : encap_out_streamer_pkg
// Brief    : Shared definitions for the encapsulation output streamer:
//            segment tags, FSM state encodings, C0 size derivation, CLOG2.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package encap_out_streamer_pkg;

  // Segment tags carried alongside each streamed word
  localparam logic [1:0] SEG_C0  = 2'd0;
  localparam logic [1:0] SEG_C1  = 2'd1;
  localparam logic [1:0] SEG_K   = 2'd2;
  localparam logic [1:0] SEG_CHK = 2'd3;

  localparam int DATA_W   = 32;
  localparam int ENTRY_W  = DATA_W + 3;  // {last, seg[1:0], data}
  localparam int C1_WORDS = 8;
  localparam int K_WORDS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_C0 = 3'd1,
    ST_RD_C1 = 3'd2,
    ST_RD_K  = 3'd3,
    ST_CHK   = 3'd4,
    ST_DRAIN = 3'd5
  } state_t;

  // GF(2^m) degree for a McEliece parameter set
  function automatic int mce_m(input int ps);
    return (ps == 1) ? 12 : 13;
  endfunction

  // Error weight for a McEliece parameter set
  function automatic int mce_t(input int ps);
    case (ps)
      1:       return 64;
      2:       return 96;
      3:       return 128;
      4:       return 119;
      default: return 128;
    endcase
  endfunction

  // Number of 32-bit words holding the m*t-bit syndrome C0
  function automatic int c0_words(input int ps);
    return (mce_m(ps) * mce_t(ps) + 31) / 32;
  endfunction

endpackage

`default_nettype wire

// File: rtl/encap_out_fifo.sv
// ============================================================================
// Module   : encap_out_fifo
// Brief    : 2-entry valid/ready FIFO; head entry is driven straight from
//            storage registers so there is no ready->valid combinational path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module encap_out_fifo #(
  parameter int WIDTH = 35
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_head,
  output logic             o_valid,
  output logic             o_pop,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;

  assign o_valid = (r_count != 2'd0);
  assign o_pop   = o_valid & i_ready;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage, pointers and occupancy; simultaneous push/pop keeps occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (o_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, i_push} - {1'b0, o_pop};
    end
  end

endmodule

`default_nettype wire

// File: rtl/encap_out_streamer.sv
// ============================================================================
// Module   : encap_out_streamer
// Brief    : On a rising encap_done, reads C0, C1 and K from the core's
//            synchronous read ports and streams them as valid/ready words.
//            Optional macro OUT_CHECKSUM_EN appends an XOR checksum word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

module encap_out_streamer
  import encap_out_streamer_pkg::*;
#(
  parameter int PARAMETER_SET = 1
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           encap_done,
  output logic                                           rd_C0,
  output logic [`CLOG2(c0_words(PARAMETER_SET))-1:0]     C0_addr,
  input  logic [31:0]                                    C0_out,
  output logic                                           rd_C1,
  output logic [2:0]                                     C1_addr,
  input  logic [31:0]                                    C1_out,
  output logic                                           rd_K,
  output logic [2:0]                                     K_addr,
  input  logic [31:0]                                    K_out,
  output logic [31:0]                                    dout,
  output logic                                           dout_valid,
  input  logic                                           dout_ready,
  output logic [1:0]                                     dout_seg,
  output logic                                           dout_last,
  output logic                                           busy,
  output logic                                           done
);

  localparam int C0_WORDS = c0_words(PARAMETER_SET);
  localparam int C0_AW    = `CLOG2(C0_WORDS);
  localparam int ADDR_W   = (C0_AW > 3) ? C0_AW : 3;

  localparam logic [ADDR_W-1:0] c_C0_LAST = ADDR_W'(C0_WORDS - 1);
  localparam logic [ADDR_W-1:0] c_C1_LAST = ADDR_W'(C1_WORDS - 1);
  localparam logic [ADDR_W-1:0] c_K_LAST  = ADDR_W'(K_WORDS - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   w_addr_next;
  logic                r_enc_prev;
  logic                w_rise;
  logic                w_issue;
  logic [1:0]          w_issue_seg;
  logic                w_issue_last;
  logic                w_chk_push;
  logic                w_done_set;
  logic                r_rd_valid;
  logic [1:0]          r_rd_seg;
  logic                r_rd_last;
  logic                r_done;
  logic [31:0]         w_rd_data;
  logic                w_push;
  logic [ENTRY_W-1:0]  w_push_data;
  logic [ENTRY_W-1:0]  w_head;
  logic                w_valid;
  logic                w_pop;
  logic [1:0]          w_count;
  logic [2:0]          w_used;
  logic                w_room;

  assign w_rise = encap_done & ~r_enc_prev;

  // Credit: buffered words plus the read on the bus, less the word leaving now
  assign w_used = {1'b0, w_count} + {2'b00, r_rd_valid};
  assign w_room = (w_used - {2'b00, w_pop}) < 3'd2;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, read issue and address sequencing
  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_issue      = 1'b0;
    w_issue_seg  = SEG_C0;
    w_issue_last = 1'b0;
    w_chk_push   = 1'b0;
    w_done_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_next = ST_RD_C0;
          w_addr_next  = '0;
        end
      end
      ST_RD_C0: begin
        w_issue_seg = SEG_C0;
        if (w_room) begin
          w_issue = 1'b1;
          if (r_addr == c_C0_LAST) begin
            w_state_next = ST_RD_C1;
            w_addr_next  = '0;
          end else begin
            w_addr_next = r_addr + ADDR_W'(1);
          end
        end
      end
      ST_RD_C1: begin
        w_issue_seg = SEG_C1;
        if (w_room) begin
          w_issue = 1'b1;
          if (r_addr == c_C1_LAST) begin
            w_state_next = ST_RD_K;
            w_addr_next  = '0;
          end else begin
            w_addr_next = r_addr + ADDR_W'(1);
          end
        end
      end
      ST_RD_K: begin
        w_issue_seg = SEG_K;
        if (w_room) begin
          w_issue = 1'b1;
          if (r_addr == c_K_LAST) begin
`ifdef OUT_CHECKSUM_EN
            w_state_next = ST_CHK;
`else
            w_issue_last = 1'b1;
            w_state_next = ST_DRAIN;
`endif
            w_addr_next  = '0;
          end else begin
            w_addr_next = r_addr + ADDR_W'(1);
          end
        end
      end
`ifdef OUT_CHECKSUM_EN
      // Checksum is final only once every data word has been accepted
      ST_CHK: begin
        if ((w_count == 2'd0) && !r_rd_valid) begin
          w_chk_push   = 1'b1;
          w_state_next = ST_DRAIN;
        end
      end
`endif
      ST_DRAIN: begin
        if (w_pop && w_head[ENTRY_W-1]) begin
          w_done_set   = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Address counter, start edge detector, read tag pipeline and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_enc_prev <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_seg   <= SEG_C0;
      r_rd_last  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_addr     <= w_addr_next;
      r_enc_prev <= encap_done;
      r_rd_valid <= w_issue;
      r_rd_seg   <= w_issue_seg;
      r_rd_last  <= w_issue_last;
      r_done     <= w_done_set;
    end
  end

  // Select the read port matching the tag of the read issued last cycle
  always_comb begin
    w_rd_data = K_out;
    case (r_rd_seg)
      SEG_C0:  w_rd_data = C0_out;
      SEG_C1:  w_rd_data = C1_out;
      default: w_rd_data = K_out;
    endcase
  end

`ifdef OUT_CHECKSUM_EN
  logic [31:0] r_acc;

  // XOR of every word accepted by the sink, cleared at transfer start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if ((r_state == ST_IDLE) && w_rise) begin
      r_acc <= '0;
    end else if (w_pop) begin
      r_acc <= r_acc ^ w_head[31:0];
    end
  end

  assign w_push      = r_rd_valid | w_chk_push;
  assign w_push_data = w_chk_push ? {1'b1, SEG_CHK, r_acc}
                                  : {r_rd_last, r_rd_seg, w_rd_data};
`else
  assign w_push      = r_rd_valid;
  assign w_push_data = {r_rd_last, r_rd_seg, w_rd_data};
`endif

  encap_out_fifo #(
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_ready     (dout_ready),
    .o_head      (w_head),
    .o_valid     (w_valid),
    .o_pop       (w_pop),
    .o_count     (w_count)
  );

  assign rd_C0   = w_issue && (r_state == ST_RD_C0);
  assign rd_C1   = w_issue && (r_state == ST_RD_C1);
  assign rd_K    = w_issue && (r_state == ST_RD_K);
  assign C0_addr = (r_state == ST_RD_C0) ? r_addr[C0_AW-1:0] : '0;
  assign C1_addr = (r_state == ST_RD_C1) ? r_addr[2:0] : 3'd0;
  assign K_addr  = (r_state == ST_RD_K)  ? r_addr[2:0] : 3'd0;

  assign dout       = w_head[31:0];
  assign dout_seg   = w_head[33:32];
  assign dout_last  = w_head[ENTRY_W-1];
  assign dout_valid = w_valid;
  assign busy       = (r_state != ST_IDLE);
  assign done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_encap_out_streamer.sv
// ============================================================================
// Module   : tb_encap_out_streamer
// Brief    : Directed self-checking bench for encap_out_streamer (set 1).
//            Honours OUT_CHECKSUM_EN for the checksum scenario.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_encap_out_streamer;
  import encap_out_streamer_pkg::*;

  localparam int C0W = c0_words(1);
`ifdef OUT_CHECKSUM_EN
  localparam int NW       = C0W + 16 + 1;
  localparam int DONE_LAT = 45;
`else
  localparam int NW       = C0W + 16;
  localparam int DONE_LAT = 43;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   encap_done = 1'b0;
  logic                   dout_ready = 1'b0;
  logic                   rd_C0, rd_C1, rd_K;
  logic [$clog2(C0W)-1:0] C0_addr;
  logic [2:0]             C1_addr, K_addr;
  logic [31:0]            C0_out = '0, C1_out = '0, K_out = '0;
  logic [31:0]            dout;
  logic                   dout_valid, dout_last, busy, done;
  logic [1:0]             dout_seg;

  logic [31:0] c0_mem [C0W];
  logic [31:0] c1_mem [8];
  logic [31:0] k_mem  [8];

  logic [31:0] exp_data [64];
  logic [1:0]  exp_seg  [64];
  logic        exp_last [64];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  encap_out_streamer #(.PARAMETER_SET(1)) dut (
    .clk(clk), .rst_n(rst_n), .encap_done(encap_done),
    .rd_C0(rd_C0), .C0_addr(C0_addr), .C0_out(C0_out),
    .rd_C1(rd_C1), .C1_addr(C1_addr), .C1_out(C1_out),
    .rd_K(rd_K), .K_addr(K_addr), .K_out(K_out),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_seg(dout_seg), .dout_last(dout_last), .busy(busy), .done(done)
  );

  // Core read ports: data one cycle after the strobe
  always @(posedge clk) begin
    if (rd_C0) C0_out <= c0_mem[C0_addr];
    if (rd_C1) C1_out <= C1_mem_rd(C1_addr);
    if (rd_K)  K_out  <= k_mem[K_addr];
  end

  function automatic logic [31:0] C1_mem_rd(input logic [2:0] a);
    return c1_mem[a];
  endfunction

  // Stream monitor: records accepted words and protocol violations
  int          n_got = 0, n_strobe = 0, n_done = 0, outstanding = 0;
  int          credit_viol = 0, multi_viol = 0, stab_viol = 0, seg3_seen = 0;
  logic [31:0] got_data [512];
  logic [1:0]  got_seg  [512];
  logic        got_last [512];
  logic        prev_stall = 1'b0;
  logic [34:0] prev_word = '0;

  always @(negedge clk) begin : monitor
    int s;
    int hs;
    int dec;
    if (!rst_n) begin
      prev_stall  = 1'b0;
      outstanding = 0;
    end else begin
      s   = int'(rd_C0) + int'(rd_C1) + int'(rd_K);
      hs  = (dout_valid && dout_ready) ? 1 : 0;
      dec = (hs == 1 && dout_seg != SEG_CHK) ? 1 : 0;
      if (s > 1) multi_viol++;
      if (s > 0 && (outstanding - dec) >= 2) credit_viol++;
      if (prev_stall && (!dout_valid || {dout_last, dout_seg, dout} !== prev_word)) stab_viol++;
      if (dout_valid && dout_seg == SEG_CHK) seg3_seen++;
      if (done) n_done++;
      if (hs == 1) begin
        if (n_got < 512) begin
          got_data[n_got] = dout;
          got_seg[n_got]  = dout_seg;
          got_last[n_got] = dout_last;
        end
        n_got++;
      end
      outstanding = outstanding + s - dec;
      n_strobe    = n_strobe + s;
      prev_stall  = dout_valid && !dout_ready;
      prev_word   = {dout_last, dout_seg, dout};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  task automatic load_pattern;
    for (int i = 0; i < C0W; i++) c0_mem[i] = 32'hA500_0000 + 32'(i);
    for (int j = 0; j < 8; j++) c1_mem[j] = 32'hA500_0000 + 32'(C0W + j);
    for (int j = 0; j < 8; j++) k_mem[j]  = 32'hA500_0000 + 32'(C0W + 8 + j);
  endtask

  task automatic build_expected;
    int          n = 0;
    logic [31:0] x = '0;
    for (int i = 0; i < C0W; i++) begin
      exp_data[n] = c0_mem[i]; exp_seg[n] = SEG_C0; exp_last[n] = 1'b0; n++;
    end
    for (int j = 0; j < 8; j++) begin
      exp_data[n] = c1_mem[j]; exp_seg[n] = SEG_C1; exp_last[n] = 1'b0; n++;
    end
    for (int j = 0; j < 8; j++) begin
      exp_data[n] = k_mem[j]; exp_seg[n] = SEG_K; exp_last[n] = 1'b0; n++;
    end
`ifdef OUT_CHECKSUM_EN
    for (int i = 0; i < n; i++) x = x ^ exp_data[i];
    exp_data[n] = x; exp_seg[n] = SEG_CHK; exp_last[n] = 1'b1;
`else
    exp_last[n-1] = 1'b1;
    x = '0;
`endif
  endtask

  // Index of the first recorded word differing from the expected stream, -1 if none
  function automatic int first_err(input int base);
    for (int n = 0; n < NW; n++) begin
      if (base + n >= 512) return n;
      if (got_data[base+n] !== exp_data[n] || got_seg[base+n] !== exp_seg[n] ||
          got_last[base+n] !== exp_last[n]) return n;
    end
    return -1;
  endfunction

  task automatic start_xfer;
    encap_done = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    encap_done = 1'b1;
  endtask

  task automatic run_until_done(input int budget, input bit toggle, output int k, output bit hit);
    k = 0; hit = 1'b0;
    while (k < budget) begin
      @(posedge clk); #1;
      k++;
      if (toggle) dout_ready = ~dout_ready;
      if (done) begin hit = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; encap_done = 1'b0; dout_ready = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_tests++;
    if ({dout_valid, dout_last, dout_seg, busy, done} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, expected 000000", {dout_valid, dout_last, dout_seg, busy, done});
    end
    n_tests++;
    if (dout !== 32'h0) begin
      n_fail++; $display("FAIL reset_dout: got %h, expected 00000000", dout);
    end
    n_tests++;
    if ({rd_C0, rd_C1, rd_K, C0_addr, C1_addr, K_addr} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_rd: got %b, expected all zero", {rd_C0, rd_C1, rd_K, C0_addr, C1_addr, K_addr});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int k = 0, kd = 0, base = 0, dbase = 0, fe = 0;
    bit hit, busy1 = 1'b0;
    load_pattern(); build_expected();
    dout_ready = 1'b1;
    base = n_got; dbase = n_done;
    start_xfer();
    while (k < 10 && !dout_valid) begin
      @(posedge clk); #1; k++;
      if (k == 1) busy1 = busy;
    end
    n_tests++;
    if (k !== 3) begin n_fail++; $display("FAIL first_valid_latency: got %0d, expected 3", k); end
    n_tests++;
    if (busy1 !== 1'b1) begin n_fail++; $display("FAIL busy_after_start: got %b, expected 1", busy1); end
    run_until_done(200, 1'b0, kd, hit);
    n_tests++;
    if (!hit || (k + kd) !== DONE_LAT) begin
      n_fail++; $display("FAIL done_latency: got %0d (hit %0d), expected %0d", k + kd, hit, DONE_LAT);
    end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_with_done: got %b, expected 0", busy); end
    repeat (3) @(posedge clk); #1;
    n_tests++;
    if (n_got - base !== NW) begin n_fail++; $display("FAIL basic_count: got %0d, expected %0d", n_got - base, NW); end
    fe = first_err(base);
    n_tests++;
    if (fe !== -1) begin n_fail++; $display("FAIL basic_stream: first bad word %0d, expected none", fe); end
    n_tests++;
    if (n_done - dbase !== 1) begin n_fail++; $display("FAIL basic_done_pulses: got %0d, expected 1", n_done - dbase); end
  endtask

  task automatic test_ready_toggle;
    int kd = 0, base = n_got, cb = credit_viol, mb = multi_viol, sb = stab_viol, fe = 0;
    bit hit;
    dout_ready = 1'b1;
    start_xfer();
    run_until_done(400, 1'b1, kd, hit);
    dout_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    n_tests++;
    if (!hit) begin n_fail++; $display("FAIL toggle_done: got no done in %0d cycles, expected done", kd); end
    fe = first_err(base);
    n_tests++;
    if (fe !== -1 || n_got - base !== NW) begin
      n_fail++; $display("FAIL toggle_stream: bad word %0d count %0d, expected none and %0d", fe, n_got - base, NW);
    end
    n_tests++;
    if (credit_viol - cb !== 0) begin n_fail++; $display("FAIL toggle_credit: got %0d violations, expected 0", credit_viol - cb); end
    n_tests++;
    if (stab_viol - sb !== 0) begin n_fail++; $display("FAIL toggle_stable: got %0d violations, expected 0", stab_viol - sb); end
    n_tests++;
    if (multi_viol - mb !== 0) begin n_fail++; $display("FAIL toggle_one_strobe: got %0d violations, expected 0", multi_viol - mb); end
  endtask

  task automatic test_stall_start;
    int kd = 0, base = n_got, sbase = n_strobe, fe = 0, sb = stab_viol;
    bit hit;
    dout_ready = 1'b0;
    start_xfer();
    repeat (20) @(posedge clk); #1;
    n_tests++;
    if (n_strobe - sbase !== 2) begin n_fail++; $display("FAIL stall_reads: got %0d, expected 2", n_strobe - sbase); end
    n_tests++;
    if (!dout_valid || dout !== 32'hA500_0000 || dout_seg !== SEG_C0) begin
      n_fail++; $display("FAIL stall_head: got v=%b %h seg %0d, expected v=1 a5000000 seg 0", dout_valid, dout, dout_seg);
    end
    dout_ready = 1'b1;
    run_until_done(200, 1'b0, kd, hit);
    repeat (3) @(posedge clk); #1;
    fe = first_err(base);
    n_tests++;
    if (!hit || fe !== -1 || n_got - base !== NW) begin
      n_fail++; $display("FAIL stall_stream: hit %0d bad word %0d count %0d, expected 1, none, %0d", hit, fe, n_got - base, NW);
    end
    n_tests++;
    if (stab_viol - sb !== 0) begin n_fail++; $display("FAIL stall_stable: got %0d violations, expected 0", stab_viol - sb); end
  endtask

  task automatic test_double_start;
    int k = 0, base = n_got, dbase = n_done, fe = 0;
    bit hit = 1'b0;
    dout_ready = 1'b1;
    start_xfer();
    while (k < 200) begin
      @(posedge clk); #1; k++;
      if (k == 5)  encap_done = 1'b0;
      if (k == 10) encap_done = 1'b1;
      if (done) begin hit = 1'b1; break; end
    end
    repeat (60) @(posedge clk); #1;
    fe = first_err(base);
    n_tests++;
    if (!hit || fe !== -1 || n_got - base !== NW) begin
      n_fail++; $display("FAIL double_stream: hit %0d bad word %0d count %0d, expected 1, none, %0d", hit, fe, n_got - base, NW);
    end
    n_tests++;
    if (n_done - dbase !== 1) begin n_fail++; $display("FAIL double_done_pulses: got %0d, expected 1", n_done - dbase); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL double_idle: got busy %b, expected 0", busy); end
  endtask

  task automatic test_reset_mid;
    int k = 0, kd = 0, base = n_got, fe = 0;
    bit hit;
    dout_ready = 1'b1;
    start_xfer();
    while (k < 100 && (n_got - base) < 15) begin @(posedge clk); #1; k++; end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({dout_valid, busy, done, rd_C0, rd_C1, rd_K, dout_last, dout_seg} !== 9'b0 || dout !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got v=%b busy=%b rd=%b dout=%h, expected all zero",
                         dout_valid, busy, rd_C0 | rd_C1 | rd_K, dout);
    end
    encap_done = 1'b0;
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    base = n_got;
    start_xfer();
    run_until_done(200, 1'b0, kd, hit);
    repeat (3) @(posedge clk); #1;
    fe = first_err(base);
    n_tests++;
    if (!hit || fe !== -1 || n_got - base !== NW) begin
      n_fail++; $display("FAIL reset_mid_restart: hit %0d bad word %0d count %0d, expected 1, none, %0d", hit, fe, n_got - base, NW);
    end
  endtask

  task automatic test_checksum;
    int kd = 0, base = n_got, s3 = seg3_seen, fe = 0;
    bit hit;
`ifdef OUT_CHECKSUM_EN
    for (int i = 0; i < C0W; i++) c0_mem[i] = 32'h1;
    for (int j = 0; j < 8; j++) begin c1_mem[j] = 32'h1; k_mem[j] = 32'h1; end
    k_mem[7] = 32'hF0;
    build_expected();
    dout_ready = 1'b1;
    start_xfer();
    run_until_done(200, 1'b0, kd, hit);
    repeat (3) @(posedge clk); #1;
    n_tests++;
    if (!hit || got_data[base+40] !== 32'h0000_00F1 || got_seg[base+40] !== 2'd3 || got_last[base+40] !== 1'b1) begin
      n_fail++; $display("FAIL checksum_word: got %h seg %0d last %b, expected 000000f1 seg 3 last 1",
                         got_data[base+40], got_seg[base+40], got_last[base+40]);
    end
    fe = first_err(base);
    n_tests++;
    if (fe !== -1 || n_got - base !== 41) begin
      n_fail++; $display("FAIL checksum_stream: bad word %0d count %0d, expected none and 41", fe, n_got - base);
    end
    n_tests++;
    if (seg3_seen - s3 < 1) begin n_fail++; $display("FAIL checksum_tag_seen: got %0d, expected >0", seg3_seen - s3); end
`else
    kd = 0; hit = 1'b0; fe = base;
    n_tests++;
    if (seg3_seen !== 0) begin n_fail++; $display("FAIL no_checksum_tag: got %0d tag-3 cycles, expected 0", seg3_seen - s3); end
    n_tests++;
    if (got_last[fe-1] !== 1'b1 || got_seg[fe-1] !== SEG_K || got_last[fe-2] !== 1'b0) begin
      n_fail++; $display("FAIL k7_last: got last=%b seg=%0d prev_last=%b, expected 1 2 0",
                         got_last[fe-1], got_seg[fe-1], got_last[fe-2]);
    end
`endif
  endtask

  initial begin
    load_pattern();
    test_reset();
    test_basic();
    test_ready_toggle();
    test_stall_start();
    test_double_start();
    test_reset_mid();
    test_checksum();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
